// File: rtl/request_unit_pkg.sv
// Shared types and default sizing for the core-to-ram request sequencer.
package request_unit_pkg;

    localparam int ADDR_W_DEF      = 5;
    localparam int DATA_W_DEF      = 32;
    localparam int ACK_TIMEOUT_DEF = 15;
    localparam int TIMER_W         = $clog2(ACK_TIMEOUT_DEF + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4,
        WB    = 3'd5,
        ERR   = 3'd6
    } state_t;

endpackage

// File: rtl/request_unit_ack_timer.sv
// Wait-cycle counter for an outstanding ram request; flags the edge on which
// the wait would reach LIMIT without an acknowledge.
module ack_timer
    import request_unit_pkg::*;
#(
    parameter int LIMIT = ACK_TIMEOUT_DEF,
    parameter int W     = TIMER_W
) (
    input  logic clk,
    input  logic nRst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (enable)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // Expiry is the edge that would push the count to LIMIT, so an ack on that
    // same edge still wins (enable is low whenever the ack is present).
    assign expired = enable && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/request_unit.sv
// Sequences instruction fetch and load/store accesses of the single-cycle core
// against the shared ram, latching returned data and strobing the PC.
module request_unit
    import request_unit_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              dmem_ren,
    input  logic              dmem_wen,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              advance,
    output logic              mem_err,
    output logic              read_enable,
    output logic              write_enable,
    output logic [ADDR_W-1:0] address_IM,
    output logic [ADDR_W-1:0] address_DM,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] instr_out,
    input  logic              pc_enable
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] dmem_rdata_q, dmem_rdata_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [ADDR_W-1:0] address_im_q, address_im_d;
    logic [ADDR_W-1:0] address_dm_q, address_dm_d;
    logic              read_enable_q, read_enable_d;
    logic              write_enable_q, write_enable_d;
    logic              advance_q, advance_d;
    logic              mem_err_q, mem_err_d;
    logic              waiting, tmr_clear, tmr_en, tmr_expired;

    assign waiting   = state_q inside {FETCH, READ, WRITE};
    assign tmr_en    = waiting && !pc_enable;
    assign tmr_clear = (state_d inside {FETCH, READ, WRITE}) && (state_d != state_q);

    ack_timer #(
        .LIMIT (ACK_TIMEOUT),
        .W     ($clog2(ACK_TIMEOUT + 1))
    ) u_ack_timer (
        .clk     (clk),
        .nRst    (nRst),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (pc_enable) state_d = EXEC;
                   else if (tmr_expired) state_d = ERR;
            EXEC:  if (dmem_wen) state_d = WRITE;
                   else if (dmem_ren) state_d = READ;
                   else state_d = WB;
            READ,
            WRITE: if (pc_enable) state_d = WB;
                   else if (tmr_expired) state_d = ERR;
            WB:    state_d = FETCH;
            ERR:   state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_d      = instr_q;
        dmem_rdata_d = dmem_rdata_q;
        data_in_d    = data_in_q;
        address_im_d = address_im_q;
        address_dm_d = address_dm_q;
        // Captures are gated by state so acks outside FETCH/READ never land.
        if (state_q == FETCH && pc_enable)
            instr_d = instr_out;
        if (state_q == READ && pc_enable)
            dmem_rdata_d = data_out;
        if (state_q == IDLE || state_q == WB)
            address_im_d = pc;
        if (state_q == EXEC) begin
            if (dmem_wen || dmem_ren)
                address_dm_d = dmem_addr;
            if (dmem_wen)
                data_in_d = dmem_wdata;
        end
        // Request strobes follow the next state so they are flop outputs.
        read_enable_d  = (state_d == FETCH) || (state_d == READ);
        write_enable_d = (state_d == WRITE);
        advance_d      = (state_d == WB);
        mem_err_d      = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q        <= IDLE;
            instr_q        <= '0;
            dmem_rdata_q   <= '0;
            data_in_q      <= '0;
            address_im_q   <= '0;
            address_dm_q   <= '0;
            read_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            advance_q      <= 1'b0;
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            dmem_rdata_q   <= dmem_rdata_d;
            data_in_q      <= data_in_d;
            address_im_q   <= address_im_d;
            address_dm_q   <= address_dm_d;
            read_enable_q  <= read_enable_d;
            write_enable_q <= write_enable_d;
            advance_q      <= advance_d;
            mem_err_q      <= mem_err_d;
        end
    end

    assign instr        = instr_q;
    assign dmem_rdata   = dmem_rdata_q;
    assign data_in      = data_in_q;
    assign address_IM   = address_im_q;
    assign address_DM   = address_dm_q;
    assign read_enable  = read_enable_q;
    assign write_enable = write_enable_q;
    assign advance      = advance_q;
    assign mem_err      = mem_err_q;

endmodule
